dp_scrambler_multi: RTL

//  Parametrised DisplayPort main-link scrambler: LANES lanes x SYMS symbols/cycle, 8b + K flag per symbol.

---
 rtl/dp_scrambler_multi.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/dp_scrambler_multi.sv
// -----------------------------------------------------------------------------
// dp_scrambler_multi
//
// DisplayPort main-link scrambler for LANES lanes x SYMS symbols per cycle.
// Each symbol is 8 bits plus a K flag. The block sits between the stream
// packer and the 8b/10b encoders.
//
// One LFSR (x^16+x^5+x^4+x^3+1, Galois form, seed 16'hFFFF) is shared by all
// lanes. Lane l, slot s uses the same key byte as lane 0, slot s. Slots within
// a cycle are processed in wire order (slot 0 first) as an unrolled chain.
// The LFSR advances 8 steps per slot. SR slots are the exception: they reload
// the seed instead of advancing.
//
// Every BS_PERIOD-th BS symbol (K28.5) is replaced by SR (K28.0) on all lanes.
// The first BS after reset is always replaced. BS detection looks at lane 0
// only, and the other lanes follow its decision.
//
// Ports
//   clk        in   1             clock
//   rstn       in   1             asynchronous active-low reset
//   scr_dis    in   1             1 = data symbols pass unscrambled (LFSR still runs)
//   in_valid   in   1             qualifies indata/inisk; LFSR frozen when 0
//   indata     in   LANES*SYMS*8  lane l, symbol s at [(l*SYMS+s)*8 +: 8]
//   inisk      in   LANES*SYMS    K flag, same indexing as indata
//   out_valid  out  1             in_valid delayed by one clock
//   outdata    out  LANES*SYMS*8  scrambled symbols (held while out_valid=0)
//   outisk     out  LANES*SYMS    K flags (held while out_valid=0)
//   sr_pulse   out  1             high for the output cycle that carries an SR
// -----------------------------------------------------------------------------
module dp_scrambler_multi #(
   parameter int LANES     = 1,
   parameter int SYMS      = 2,
   parameter int BS_PERIOD = 512
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    scr_dis,
   input  logic                    in_valid,
   input  logic [LANES*SYMS*8-1:0] indata,
   input  logic [LANES*SYMS-1:0]   inisk,
   output logic                    out_valid,
   output logic [LANES*SYMS*8-1:0] outdata,
   output logic [LANES*SYMS-1:0]   outisk,
   output logic                    sr_pulse
);

   localparam int          NSYM   = LANES * SYMS;
   // BS_PERIOD is a power of two, so a CNT_W-bit counter wraps at exactly
   // BS_PERIOD. A period of 1 still gets a 1-bit counter, which is held at zero.
   localparam int          CNT_W  = (BS_PERIOD > 1) ? $clog2(BS_PERIOD) : 1;
   localparam logic [7:0]  SYM_BS = 8'hBC;     // K28.5
   localparam logic [7:0]  SYM_SR = 8'h1C;     // K28.0
   localparam logic [15:0] POLY   = 16'h0039;  // x^5+x^4+x^3+1; x^16 is the bit shifted out
   localparam logic [15:0] SEED   = 16'hFFFF;

   typedef logic [CNT_W-1:0] cnt_t;

   // Registered state
   logic [15:0]      lfsr_q;
   cnt_t             bs_cnt_q;

   // Next-state / next-output values from the slot chain
   logic [15:0]      lfsr_d;
   cnt_t             bs_cnt_d;
   logic [NSYM*8-1:0] data_d;
   logic [NSYM-1:0]  isk_d;
   logic             sr_d;

   // Working values carried from slot to slot inside the chain
   logic [15:0]      lfsr_v;
   cnt_t             cnt_v;
   logic [23:0]      adv;
   logic             is_bs;

   // Runs the LFSR for one symbol slot. Returns {state after 8 steps, key byte}.
   // Key bit i is the MSB before step i, so key bit 0 is the first bit on the wire.
   function automatic logic [23:0] lfsr_byte(input logic [15:0] seed);
      logic [15:0] st;
      logic [7:0]  key;
      st  = seed;
      key = '0;
      for (int i = 0; i < 8; i++) begin
         key[i] = st[15];
         st     = {st[14:0], 1'b0} ^ (st[15] ? POLY : 16'h0000);
      end
      return {st, key};
   endfunction

   // Advances the BS counter modulo BS_PERIOD.
   function automatic cnt_t cnt_inc(input cnt_t c);
      if (BS_PERIOD == 1)
         return '0;
      return c + cnt_t'(1);
   endfunction

   // Slot chain. Each slot sees the LFSR state and BS count left behind by the
   // previous slot. An SR therefore reseeds the key for the slot after it, even
   // when that slot is in the same cycle.
   always_comb begin
      // NOTE: every variable gets its default before any branch so no latch can be inferred.
      data_d = indata;
      isk_d  = inisk;
      sr_d   = 1'b0;
      lfsr_v = lfsr_q;
      cnt_v  = bs_cnt_q;
      adv    = '0;
      is_bs  = 1'b0;

      for (int s = 0; s < SYMS; s++) begin
         is_bs = inisk[s] && (indata[s*8 +: 8] == SYM_BS);

         if (is_bs && (cnt_v == '0)) begin
            // SR replacement: all lanes, forced K, LFSR reseeded, no key used.
            for (int l = 0; l < LANES; l++) begin
               data_d[(l*SYMS+s)*8 +: 8] = SYM_SR;
               isk_d[l*SYMS+s]           = 1'b1;
            end
            lfsr_v = SEED;
            sr_d   = 1'b1;
         end else begin
            adv    = lfsr_byte(lfsr_v);
            lfsr_v = adv[23:8];
            // K symbols (including BS that is not replaced) pass untouched.
            // scr_dis only gates the XOR; the key position still advances.
            if (!scr_dis) begin
               for (int l = 0; l < LANES; l++) begin
                  if (!inisk[l*SYMS+s])
                     data_d[(l*SYMS+s)*8 +: 8] = indata[(l*SYMS+s)*8 +: 8] ^ adv[7:0];
               end
            end
         end

         // Every BS is counted, whether or not it became SR.
         if (is_bs)
            cnt_v = cnt_inc(cnt_v);
      end

      lfsr_d   = lfsr_v;
      bs_cnt_d = cnt_v;
   end

   // Output and state registers. State only moves on valid cycles. On bubbles,
   // the outputs hold and only out_valid/sr_pulse drop.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         outdata   <= '0;
         outisk    <= '0;
         sr_pulse  <= 1'b0;
         lfsr_q    <= SEED;
         bs_cnt_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         out_valid <= in_valid;
         sr_pulse  <= in_valid & sr_d;
         if (in_valid) begin
            outdata  <= data_d;
            outisk   <= isk_d;
            lfsr_q   <= lfsr_d;
            bs_cnt_q <= bs_cnt_d;
         end
      end
   end

endmodule
